// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data RAM between the CPU load/store path
// and the video scan-out reader, with CPU stall generation and a saturating stall-cycle counter.
module dmem_arbiter #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_WIDTH-1:0]      cpu_addr,
    input  logic [DATA_WIDTH-1:0]      cpu_wdata,
    output logic [DATA_WIDTH-1:0]      cpu_rdata,
    output logic                       cpu_ack,
    output logic                       cpu_stall,
    input  logic                       vid_req,
    input  logic [ADDR_WIDTH-1:0]      vid_addr,
    output logic [DATA_WIDTH-1:0]      vid_rdata,
    output logic                       vid_ack,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_we,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_CPU = 2'd1;
    localparam logic [1:0] BUSY_VID = 2'd2;
    localparam logic       CPU      = 1'b0;
    localparam logic       VID      = 1'b1;

    logic [1:0]                 state_q, state_d;
    logic                       last_q, last_d;
    logic                       we_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      cpu_rdata_q;
    logic [DATA_WIDTH-1:0]      vid_rdata_q;
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    logic                       grant_cpu, grant_vid;

    // Grants exist only in IDLE and are suppressed under reset so a coincident store never writes.
    always_comb begin
        grant_cpu = (state_q == IDLE) & ~reset & cpu_req & (~vid_req | (last_q == VID));
        grant_vid = (state_q == IDLE) & ~reset & vid_req & ~grant_cpu;
        mem_addr  = grant_cpu ? cpu_addr : grant_vid ? vid_addr : addr_q;
        mem_wdata = grant_cpu ? cpu_wdata : wdata_q;
        mem_we    = grant_cpu & cpu_we;
        cpu_ack   = ~reset & (state_q == BUSY_CPU);
        vid_ack   = ~reset & (state_q == BUSY_VID);
        cpu_rdata = (cpu_ack & ~we_q) ? mem_rdata : cpu_rdata_q;
        vid_rdata = vid_ack ? mem_rdata : vid_rdata_q;
        cpu_stall = cpu_req & ~cpu_ack;
        state_d   = grant_cpu ? BUSY_CPU : grant_vid ? BUSY_VID : IDLE;
        last_d    = grant_cpu ? CPU : grant_vid ? VID : last_q;
    end

    assign stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= VID;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            we_q        <= grant_cpu ? cpu_we : we_q;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            cpu_rdata_q <= cpu_rdata;
            vid_rdata_q <= vid_rdata;
            stall_q     <= stall_q + STALL_CNT_WIDTH'(cpu_stall && !(&stall_q));
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a registered-read RAM model,
// built with a 4-bit stall counter so saturation is reachable.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [3:0]  stall_cycles;
    logic [7:0]  ram [0:65535];
    int          n_vec = 0;
    int          n_err = 0;

    dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STALL_CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cpu_acks, vid_acks, exp_cnt;
        logic stall_exp;
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[16'h0010] = 8'h00;
        ram[16'h0020] = 8'h77;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_vid_ack", vid_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        tick();

        // CPU store then load
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
        #1;
        chk("st_grant_we", mem_we, 1);
        chk("st_grant_addr", mem_addr, 16'h0010);
        chk("st_grant_wdata", mem_wdata, 8'hA5);
        chk("st_grant_stall", cpu_stall, 1);
        chk("st_grant_ack", cpu_ack, 0);
        tick();
        chk("st_ack", cpu_ack, 1);
        chk("st_ack_stall", cpu_stall, 0);
        chk("st_ack_we", mem_we, 0);
        chk("st_ack_cnt", stall_cycles, 1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("st_ram", ram[16'h0010], 8'hA5);
        chk("st_idle_ack", cpu_ack, 0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        #1;
        chk("ld_grant_we", mem_we, 0);
        chk("ld_grant_stall", cpu_stall, 1);
        tick();
        chk("ld_ack", cpu_ack, 1);
        chk("ld_rdata", cpu_rdata, 8'hA5);
        chk("ld_cnt", stall_cycles, 2);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("ld_hold_rdata", cpu_rdata, 8'hA5);
        chk("ld_idle_ack", cpu_ack, 0);

        // First tie after reset goes to the CPU
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        vid_req = 1'b1; vid_addr = 16'h0007;
        #1;
        chk("tie_grant_addr", mem_addr, 16'h0005);
        chk("tie_grant_stall", cpu_stall, 1);
        tick();
        chk("tie_cpu_ack", cpu_ack, 1);
        chk("tie_cpu_rdata", cpu_rdata, 8'h5F);
        chk("tie_vid_ack0", vid_ack, 0);
        chk("tie_cnt", stall_cycles, 1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("tie_vid_grant_addr", mem_addr, 16'h0007);
        chk("tie_vid_grant_we", mem_we, 0);
        chk("tie_vid_ack_early", vid_ack, 0);
        tick();
        chk("tie_vid_ack", vid_ack, 1);
        chk("tie_vid_rdata", vid_rdata, 8'h5D);
        tick();
        vid_req = 1'b0;
        tick();

        // Continuous dual requests alternate, CPU first
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        vid_req = 1'b1; vid_addr = 16'h0040;
        cpu_acks = 0; vid_acks = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("alt_grant_addr", mem_addr, ((k / 2) % 2 == 0) ? 32'h30 : 32'h40);
            end else begin
                chk("alt_cpu_ack", cpu_ack, ((k / 2) % 2 == 0) ? 1 : 0);
                chk("alt_vid_ack", vid_ack, ((k / 2) % 2 == 1) ? 1 : 0);
                chk("alt_rdata", ((k / 2) % 2 == 0) ? cpu_rdata : vid_rdata,
                    ((k / 2) % 2 == 0) ? 32'h6A : 32'h1A);
            end
            cpu_acks += int'(cpu_ack);
            vid_acks += int'(vid_ack);
            tick();
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        chk("alt_cpu_count", cpu_acks, 4);
        chk("alt_vid_count", vid_acks, 4);
        tick();

        // Video only, five consecutive reads
        vid_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) vid_addr = 16'(k / 2);
            #1;
            chk("vid_we", mem_we, 0);
            chk("vid_cpu_ack", cpu_ack, 0);
            chk("vid_ack", vid_ack, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) chk("vid_addr", mem_addr, k / 2);
            else chk("vid_rdata", vid_rdata, 32'((k / 2) ^ 8'h5A));
            tick();
        end
        vid_req = 1'b0;
        tick();

        // Reset coincident with a store grant
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h3C; reset = 1'b1;
        #1;
        chk("rs_we", mem_we, 0);
        tick();
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        chk("rs_ram", ram[16'h0020], 8'h77);
        chk("rs_ack", cpu_ack, 0);
        chk("rs_mem_addr", mem_addr, 0);
        chk("rs_mem_wdata", mem_wdata, 0);
        chk("rs_cpu_rdata", cpu_rdata, 0);
        chk("rs_vid_rdata", vid_rdata, 0);
        chk("rs_cnt", stall_cycles, 0);
        tick();
        cpu_req = 1'b1;
        #1;
        chk("rs_retry_we", mem_we, 1);
        chk("rs_retry_addr", mem_addr, 16'h0020);
        tick();
        chk("rs_retry_ack", cpu_ack, 1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("rs_retry_ram", ram[16'h0020], 8'h3C);

        // Stall counter saturation with video contending
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0003; vid_addr = 16'h0009;
        exp_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 0) vid_req = 1'b1;
            if (c == 1) cpu_req = 1'b1;
            stall_exp = (c >= 1) && (c % 4 != 3);
            #1;
            chk("sat_stall", cpu_stall, stall_exp);
            chk("sat_cnt", stall_cycles, exp_cnt);
            if (stall_exp && exp_cnt < 15) exp_cnt++;
            tick();
        end
        chk("sat_final", stall_cycles, 15);
        cpu_req = 1'b0; vid_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("sat_reset", stall_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU load/store path (LBU/SB) and the video scan-out reader.
- Round-robin arbitration with a req/ack handshake, one access in flight at a time.
- Generates the CPU pipeline stall while a CPU access is pending.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
ADDR_WIDTH, 16, byte address width of RAM and both requester ports
DATA_WIDTH, 8, data width (byte accesses)
STALL_CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = store (SB), 0 = load (LBU); stable while cpu_req high
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU store data
cpu_rdata  out  DATA_WIDTH  CPU load data, valid in the cpu_ack cycle
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
vid_req  in  1  video read request, held until vid_ack
vid_addr  in  ADDR_WIDTH  video read address
vid_rdata  out  DATA_WIDTH  video read data, valid in the vid_ack cycle
vid_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_WIDTH  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, registered, 1-cycle latency
stall_cycles  out  STALL_CNT_WIDTH  count of cycles with cpu_stall=1, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE; cpu_ack=vid_ack=0; cpu_rdata=vid_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - last_grant=VID, so the CPU wins the first tie.
  - stall_cycles=0.
- States: IDLE, BUSY_CPU, BUSY_VID.
- IDLE, no req: mem_we=0, mem_addr holds its last value, stay in IDLE.
- IDLE, one req: grant that requester. Drive mem_addr/mem_we/mem_wdata combinationally from the winner; go to the matching BUSY state.
- IDLE, both req: grant the requester that is not last_grant. Update last_grant to the winner.
- Video is read-only: mem_we=0 whenever the video requester is granted.
- mem_we=1 only in the IDLE grant cycle of a CPU store, and is gated by ~reset.
- BUSY_CPU:
  - Assert cpu_ack for exactly one cycle.
  - Load: cpu_rdata <= mem_rdata, registered at entry so it is valid in the ack cycle.
  - Store: cpu_rdata keeps its previous value.
  - Next state is IDLE.
- BUSY_VID: same as BUSY_CPU with vid_ack/vid_rdata; always a read.
- Latency: grant cycle plus ack cycle = 2 cycles per access; peak throughput 1 access per 2 cycles.
- Handshake:
  - A requester keeps req, we, addr and wdata stable from assertion through its ack cycle.
  - It must drive req low in the cycle after ack unless it wants a new access.
  - A req still high in the IDLE cycle after ack is a new request.
- Fairness: under continuous dual requests, grants strictly alternate. Worst-case wait is one access (2 cycles) before grant.
- cpu_stall is combinational, so the CPU pipeline freezes in the same cycle cpu_req rises. It is 0 in the ack cycle.
- stall_cycles: increments every cycle cpu_stall=1 and holds at all-ones (no wrap). Reset clears it.
- Reset mid-operation:
  - An in-flight access is abandoned with no ack.
  - A store whose grant cycle coincides with reset=1 does not write.
  - The state after reset is IDLE with last_grant=VID.
- Simultaneous events: vid_req rising in a BUSY_CPU cycle is evaluated in the following IDLE cycle. No preemption of an in-flight access.

Test Plan:
- CPU store then load: cpu_we=1, addr=0x0010, wdata=0xA5 → mem_we=1 in grant cycle, cpu_ack next cycle. Then load addr=0x0010 → cpu_ack with cpu_rdata=0xA5 two cycles after req; cpu_stall=1 for exactly 1 cycle per access.
- First tie after reset: cpu_req and vid_req both high from the first cycle (CPU load, video read) → CPU granted first, video second; acks in cycles 2 and 4; vid_rdata matches the RAM preload.
- Continuous both-req for 8 accesses → grant order CPU,VID,CPU,VID,...; each requester gets 4 acks; no requester waits more than 2 cycles past its turn.
- Video only, vid_req held continuously over 5 accesses at addrs 0..4 → 5 vid_acks 2 cycles apart; mem_we never 1; cpu_ack never 1.
- Reset during a CPU store grant cycle (cpu_we=1, addr=0x0020, wdata=0x3C) → RAM[0x0020] unchanged and no cpu_ack. After reset deasserts, all outputs are at reset values, and the retried store completes normally.
- STALL_CNT_WIDTH=4, CPU req while video holds the RAM repeatedly → stall_cycles increments per stall cycle and stops at 15; reset returns it to 0.
